pll_seq_ctrl: RTL and testbench

//  Power-up and supervision sequencer for the board rPLL (18 MHz in, 108/54 MHz out).

---
 rtl/pll_ctrl_pkg.sv | 59 +++++
 rtl/pll_seq_ctrl_sync_2ff.sv | 25 ++
 rtl/pll_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_pll_seq_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and default timing for the rPLL power-up sequencer.
// Timing constants are in 18 MHz reference-clock cycles.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN,
    PHASE,
    FAIL
  } state_t;

  localparam int PSW = 4;

  localparam logic [PSW-1:0] DUTY_DEF = 4'b1000;

  localparam int RST_CYCLES_D    = 18;
  localparam int LOCK_TIMEOUT_D  = 18000;
  localparam int STABLE_CYCLES_D = 256;
  localparam int SETTLE_CYCLES_D = 64;
  localparam int MAX_RETRY_D     = 3;

  typedef struct packed {
    logic pll_reset;
    logic sys_rst_n;
    logic pll_ok;
  } outs_t;

  function automatic outs_t st_outs(input state_t s);
    outs_t o;
    o = '0;
    case (s)
      PLL_RST, FAIL: o.pll_reset = 1'b1;
      RUN: begin
        o.sys_rst_n = 1'b1;
        o.pll_ok    = 1'b1;
      end
      PHASE: o.sys_rst_n = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic int cnt_max(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/pll_seq_ctrl_sync_2ff.sv
// Generic 1-bit two-flop synchronizer with synchronous active-low reset.
// Also usable by sys_rst_n consumers in the PLL output domains.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_m;
  logic r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m <= 1'b0;
      r_q <= 1'b0;
    end else begin
      r_m <= i_d;
      r_q <= r_m;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pll_seq_ctrl.sv
// rPLL power-up/supervision sequencer: reset, lock wait with retry,
// stable-lock qualification, system reset release and PSDA phase steps.
module pll_seq_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = RST_CYCLES_D,
  parameter int LOCK_TIMEOUT  = LOCK_TIMEOUT_D,
  parameter int STABLE_CYCLES = STABLE_CYCLES_D,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_D,
  parameter int MAX_RETRY     = MAX_RETRY_D,
  parameter logic [PSW-1:0] DUTY_DEFAULT = DUTY_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pll_lock,
  output logic           pll_reset,
  output logic           pll_reset_p,
  output logic [PSW-1:0] psda,
  output logic [PSW-1:0] dutyda,
  input  logic           ph_req,
  input  logic [PSW-1:0] ph_val,
  output logic           ph_ack,
  output logic           sys_rst_n,
  output logic           pll_ok,
  output logic           pll_fail,
  output logic [1:0]     retry_cnt
);

  localparam int CMAX = cnt_max(RST_CYCLES, LOCK_TIMEOUT,
                                STABLE_CYCLES, SETTLE_CYCLES);
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] C_RST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] C_TO  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] C_STB = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] C_SET = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [1:0]    C_MR  = 2'(MAX_RETRY);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_inc;
  outs_t           r_o;
  logic [PSW-1:0]  r_psda;
  logic            r_ph_ack;
  logic            r_fail;
  logic [1:0]      r_retry;
  logic [1:0]      w_retry_inc;
  logic            w_lock_s;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (pll_lock),
    .o_q   (w_lock_s)
  );

  assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + C_ONE;
  assign w_retry_inc = (&r_retry) ? r_retry : r_retry + 2'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= PLL_RST;
      r_cnt    <= '0;
      r_o      <= st_outs(PLL_RST);
      r_psda   <= '0;
      r_ph_ack <= 1'b0;
      r_fail   <= 1'b0;
      r_retry  <= 2'd0;
    end else begin
      r_ph_ack <= 1'b0;
      r_cnt    <= w_cnt_inc;
      unique case (r_state)
        PLL_RST: begin
          if (r_cnt == C_RST) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
            r_o     <= st_outs(WAIT_LOCK);
          end
        end
        WAIT_LOCK: begin
          // the lock_s cycle seen here is the first stable cycle
          if (w_lock_s) begin
            r_state <= STABLE;
            r_cnt   <= C_ONE;
            r_o     <= st_outs(STABLE);
          end else if (r_cnt == C_TO) begin
            r_cnt <= '0;
            if (r_retry == C_MR) begin
              r_state <= FAIL;
              r_o     <= st_outs(FAIL);
              r_fail  <= 1'b1;
            end else begin
              r_state <= PLL_RST;
              r_o     <= st_outs(PLL_RST);
              r_retry <= w_retry_inc;
            end
          end
        end
        STABLE: begin
          if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
            r_o     <= st_outs(WAIT_LOCK);
          end else if (r_cnt >= C_STB) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_o     <= st_outs(RUN);
          end
        end
        RUN: begin
          if (!w_lock_s) begin
            r_state <= PLL_RST;
            r_cnt   <= '0;
            r_o     <= st_outs(PLL_RST);
          end else if (ph_req && !r_ph_ack) begin
            if (ph_val == r_psda) begin
              r_ph_ack <= 1'b1;
            end else begin
              r_psda  <= ph_val;
              r_state <= PHASE;
              r_cnt   <= '0;
              r_o     <= st_outs(PHASE);
            end
          end
        end
        PHASE: begin
          if (!w_lock_s) begin
            r_state <= PLL_RST;
            r_cnt   <= '0;
            r_o     <= st_outs(PLL_RST);
          end else if (r_cnt == C_SET) begin
            r_ph_ack <= 1'b1;
            r_state  <= RUN;
            r_cnt    <= '0;
            r_o      <= st_outs(RUN);
          end
        end
        FAIL: ;
        default: begin
          r_state <= PLL_RST;
          r_cnt   <= '0;
          r_o     <= st_outs(PLL_RST);
        end
      endcase
    end
  end

  assign pll_reset   = r_o.pll_reset;
  assign pll_reset_p = r_o.pll_reset;
  assign sys_rst_n   = r_o.sys_rst_n;
  assign pll_ok      = r_o.pll_ok;
  assign psda        = r_psda;
  assign dutyda      = DUTY_DEFAULT;
  assign ph_ack      = r_ph_ack;
  assign pll_fail    = r_fail;
  assign retry_cnt   = r_retry;

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Bench for pll_seq_ctrl with short timing constants.
// Phase acks are matched against a queue of expected results.
module tb_pll_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_reset;
  logic       pll_reset_p;
  logic [3:0] psda;
  logic [3:0] dutyda;
  logic       ph_req = 1'b0;
  logic [3:0] ph_val = 4'h0;
  logic       ph_ack;
  logic       sys_rst_n;
  logic       pll_ok;
  logic       pll_fail;
  logic [1:0] retry_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [3:0] psda_m;

  typedef struct {
    logic [3:0] psda;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  pll_seq_ctrl #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (100),
    .STABLE_CYCLES (8),
    .SETTLE_CYCLES (5),
    .MAX_RETRY     (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock    (pll_lock),
    .pll_reset   (pll_reset),
    .pll_reset_p (pll_reset_p),
    .psda        (psda),
    .dutyda      (dutyda),
    .ph_req      (ph_req),
    .ph_val      (ph_val),
    .ph_ack      (ph_ack),
    .sys_rst_n   (sys_rst_n),
    .pll_ok      (pll_ok),
    .pll_fail    (pll_fail),
    .retry_cnt   (retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // leaves the bench in cycle 0: reset edge taken, rst_n high again
  task automatic reset_dut();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cyc = 0;
    psda_m = 4'h0;
  endtask

  task automatic test_reset();
    ph_req = 1'b0;
    pll_lock = 1'b0;
    reset_dut();
    checks++;
    if ({pll_reset, pll_reset_p} !== 2'b11) begin
      errors++;
      $display("FAIL reset_pll_reset got %b want 11",
               {pll_reset, pll_reset_p});
    end
    checks++;
    if ({sys_rst_n, pll_ok, pll_fail, ph_ack} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000",
               {sys_rst_n, pll_ok, pll_fail, ph_ack});
    end
    checks++;
    if (psda !== 4'h0 || retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_regs psda %h retry %0d want 0 0",
               psda, retry_cnt);
    end
    checks++;
    if (dutyda !== 4'b1000) begin
      errors++;
      $display("FAIL dutyda got %b want 1000", dutyda);
    end
  endtask

  task automatic test_clean_start();
    logic e_sys;
    reset_dut();
    for (int c = 0; c <= 34; c++) begin
      if (cyc == 20) pll_lock = 1'b1;
      e_sys = (cyc >= 30);
      checks++;
      if (pll_reset !== (cyc <= 3) || pll_reset_p !== pll_reset) begin
        errors++;
        $display("FAIL clean_pll_reset cyc %0d got %b/%b", cyc,
                 pll_reset, pll_reset_p);
      end
      checks++;
      if (sys_rst_n !== e_sys || pll_ok !== e_sys) begin
        errors++;
        $display("FAIL clean_release cyc %0d got %b/%b want %b",
                 cyc, sys_rst_n, pll_ok, e_sys);
      end
      tick();
    end
  endtask

  task automatic test_glitch();
    logic e_sys;
    pll_lock = 1'b0;
    reset_dut();
    for (int c = 0; c <= 40; c++) begin
      pll_lock = (cyc >= 20 && cyc < 24) || (cyc >= 26);
      e_sys = (cyc >= 36);
      checks++;
      if (sys_rst_n !== e_sys) begin
        errors++;
        $display("FAIL glitch_sys_rst_n cyc %0d got %b want %b",
                 cyc, sys_rst_n, e_sys);
      end
      tick();
    end
    checks++;
    if (retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL glitch_retry got %0d want 0", retry_cnt);
    end
  endtask

  task automatic test_lock_loss();
    int k;
    int l;
    logic e_sys;
    logic e_rst;
    k = cyc;
    l = k + 10;
    pll_lock = 1'b0;
    for (int c = 0; c <= 24; c++) begin
      if (cyc == l) pll_lock = 1'b1;
      e_sys = (cyc < k + 3) || (cyc >= l + 10);
      e_rst = (cyc >= k + 3) && (cyc <= k + 6);
      checks++;
      if (sys_rst_n !== e_sys || pll_ok !== e_sys) begin
        errors++;
        $display("FAIL loss_sys_rst_n cyc %0d got %b/%b want %b",
                 cyc - k, sys_rst_n, pll_ok, e_sys);
      end
      checks++;
      if (pll_reset !== e_rst) begin
        errors++;
        $display("FAIL loss_pll_reset cyc %0d got %b want %b",
                 cyc - k, pll_reset, e_rst);
      end
      tick();
    end
    checks++;
    if (retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL loss_retry got %0d want 0", retry_cnt);
    end
  endtask

  task automatic test_phase();
    logic [3:0] tab [3];
    exp_t e;
    bit got;
    tab[0] = 4'h3;
    tab[1] = 4'h3;
    tab[2] = 4'h9;
    for (int i = 0; i < 3; i++) begin
      got = 1'b0;
      ph_req = 1'b1;
      ph_val = tab[i];
      e.psda = tab[i];
      e.cyc = (tab[i] == psda_m) ? cyc + 1 : cyc + 6;
      sb.push_back(e);
      psda_m = tab[i];
      for (int n = 0; n < 20 && !got; n++) begin
        tick();
        checks++;
        if (sys_rst_n !== 1'b1 || psda !== psda_m) begin
          errors++;
          $display("FAIL phase_hold req %0d sys %b psda %h want 1 %h",
                   i, sys_rst_n, psda, psda_m);
        end
        if (ph_ack === 1'b1) begin
          got = 1'b1;
          ph_req = 1'b0;
          e = sb.pop_front();
          checks++;
          if (cyc !== e.cyc || psda !== e.psda) begin
            errors++;
            $display("FAIL phase_ack req %0d cyc %0d psda %h want %0d %h",
                     i, cyc, psda, e.cyc, e.psda);
          end
        end
      end
      if (!got) begin
        errors++;
        void'(sb.pop_front());
        ph_req = 1'b0;
        $display("FAIL phase_ack_timeout req %0d got none want ack", i);
      end
      tick();
      checks++;
      if (ph_ack !== 1'b0) begin
        errors++;
        $display("FAIL phase_ack_pulse req %0d got %b want 0", i, ph_ack);
      end
    end
  endtask

  task automatic test_phase_lock_loss();
    int k;
    exp_t e;
    logic e_sys;
    logic e_ack;
    k = cyc;
    ph_req = 1'b1;
    ph_val = 4'h5;
    psda_m = 4'h5;
    e.psda = 4'h5;
    e.cyc = k + 19;
    sb.push_back(e);
    for (int c = 0; c <= 25; c++) begin
      if (cyc == k + 1) pll_lock = 1'b0;
      if (cyc == k + 8) pll_lock = 1'b1;
      e_sys = (cyc < k + 4) || (cyc >= k + 18);
      e_ack = (sb.size() > 0) && (cyc == sb[0].cyc);
      checks++;
      if (sys_rst_n !== e_sys) begin
        errors++;
        $display("FAIL phloss_sys_rst_n cyc %0d got %b want %b",
                 cyc - k, sys_rst_n, e_sys);
      end
      checks++;
      if (ph_ack !== e_ack) begin
        errors++;
        $display("FAIL phloss_ack cyc %0d got %b want %b",
                 cyc - k, ph_ack, e_ack);
      end
      if (ph_ack === 1'b1) begin
        ph_req = 1'b0;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checks++;
          if (psda !== e.psda) begin
            errors++;
            $display("FAIL phloss_psda got %h want %h", psda, e.psda);
          end
        end
      end
      tick();
    end
    checks++;
    if (sb.size() != 0 || ph_req !== 1'b0) begin
      errors++;
      $display("FAIL phloss_pending got %0d acks outstanding want 0",
               sb.size());
      sb.delete();
      ph_req = 1'b0;
    end
  endtask

  task automatic test_rst_mid();
    logic e_sys;
    ph_req = 1'b1;
    ph_val = 4'hA;
    tick();
    checks++;
    if (psda !== 4'hA || sys_rst_n !== 1'b1 || pll_ok !== 1'b0) begin
      errors++;
      $display("FAIL mid_phase psda %h sys %b ok %b want a 1 0",
               psda, sys_rst_n, pll_ok);
    end
    tick();
    ph_req = 1'b0;
    reset_dut();
    checks++;
    if ({pll_reset, sys_rst_n, pll_ok, ph_ack, pll_fail} !== 5'b10000
        || psda !== 4'h0 || retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset flags %b psda %h retry %0d",
               {pll_reset, sys_rst_n, pll_ok, ph_ack, pll_fail},
               psda, retry_cnt);
    end
    for (int c = 0; c <= 14; c++) begin
      e_sys = (cyc >= 12);
      checks++;
      if (sys_rst_n !== e_sys || pll_reset !== (cyc <= 3)) begin
        errors++;
        $display("FAIL mid_restart cyc %0d sys %b rst %b want %b %b",
                 cyc, sys_rst_n, pll_reset, e_sys, (cyc <= 3));
      end
      tick();
    end
  endtask

  task automatic test_no_lock();
    logic [1:0] e_rty;
    logic       e_fail;
    logic       e_rst;
    pll_lock = 1'b0;
    reset_dut();
    for (int c = 0; c <= 320; c++) begin
      e_rty = (cyc >= 208) ? 2'd2 : (cyc >= 104) ? 2'd1 : 2'd0;
      e_fail = (cyc >= 312);
      e_rst = e_fail || ((cyc % 104) <= 3);
      checks++;
      if (retry_cnt !== e_rty || pll_fail !== e_fail) begin
        errors++;
        $display("FAIL nolock_retry cyc %0d retry %0d fail %b want %0d %b",
                 cyc, retry_cnt, pll_fail, e_rty, e_fail);
      end
      checks++;
      if (pll_reset !== e_rst || sys_rst_n !== 1'b0) begin
        errors++;
        $display("FAIL nolock_reset cyc %0d rst %b sys %b want %b 0",
                 cyc, pll_reset, sys_rst_n, e_rst);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_clean_start();
    test_glitch();
    test_lock_loss();
    test_phase();
    test_phase_lock_loss();
    test_rst_mid();
    test_no_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
